// File: rtl/debounce_pkg.sv
// Shared helpers for the switch debouncer: width arithmetic and the per-channel event bundle.
package debounce_pkg;

  // Ceiling log2, defined as 0 for values of 0 and 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // Bits needed to hold every count in 0..max_count, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    int unsigned w;
    w = clog2(max_count + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Stability counter only ever holds 0..stable_ticks-1.
  function automatic int unsigned stab_width(input int unsigned stable_ticks);
    int unsigned w;
    w = clog2(stable_ticks);
    return (w < 1) ? 1 : w;
  endfunction

  typedef struct packed {
    logic rise;
    logic fall;
    logic rpt;
  } chan_evt_t;

  localparam chan_evt_t EvtNone = '{rise: 1'b0, fall: 1'b0, rpt: 1'b0};

endpackage

// File: rtl/debounce_bank_if.sv
// Input/output bundle of the debounce bank: raw buttons in, clean levels and event pulses out.
interface debounce_bank_if #(
  parameter int unsigned CHANNELS = 8
);
  logic [CHANNELS-1:0] button_in;
  logic [CHANNELS-1:0] repeat_en;
  logic [CHANNELS-1:0] db_out;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] rpt;
  logic                event_any;

  modport master (
    output button_in,
    output repeat_en,
    input  db_out,
    input  rise,
    input  fall,
    input  rpt,
    input  event_any
  );

  modport slave (
    input  button_in,
    input  repeat_en,
    output db_out,
    output rise,
    output fall,
    output rpt,
    output event_any
  );
endinterface

// File: rtl/debounce_chan.sv
// One debounced input: two-flop synchroniser, tick-qualified stability counter and key repeat.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = 32,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100,
  parameter logic        RESET_LEVEL  = 1'b0
) (
  input  logic inClk,
  input  logic n_reset,
  input  logic tick_i,
  input  logic button_i,
  input  logic repeat_en_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o,
  output logic rpt_o
);

  localparam int unsigned StabW = stab_width(STABLE_TICKS);
  localparam int unsigned RptW  = cnt_width(REPEAT_DELAY);

  localparam logic [StabW-1:0] StabLast  = StabW'(STABLE_TICKS - 1);
  localparam logic [RptW-1:0]  RptLast   = RptW'(REPEAT_DELAY - 1);
  // A rate longer than the delay cannot be expressed as a reload; fall back to the full delay.
  localparam logic [RptW-1:0]  RptReload =
      (REPEAT_RATE >= REPEAT_DELAY) ? '0 : RptW'(REPEAT_DELAY - REPEAT_RATE);

  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic [StabW-1:0] stab_q, stab_d;
  logic [RptW-1:0]  rpt_cnt_q, rpt_cnt_d;
  chan_evt_t        evt_q, evt_d;

  always_comb begin
    db_d      = db_q;
    stab_d    = stab_q;
    rpt_cnt_d = rpt_cnt_q;
    evt_d     = EvtNone;

    // Any cycle where the synchronised input agrees with the output discards progress.
    if (sync2_q == db_q) begin
      stab_d = '0;
    end else if (tick_i) begin
      if (stab_q == StabLast) begin
        db_d       = sync2_q;
        stab_d     = '0;
        evt_d.rise = sync2_q;
        evt_d.fall = ~sync2_q;
      end else begin
        stab_d = stab_q + StabW'(1);
      end
    end

    // Counter is idle while released, so a rise always starts it from zero.
    if (!db_q || !repeat_en_i) begin
      rpt_cnt_d = '0;
    end else if (tick_i) begin
      if (rpt_cnt_q == RptLast) begin
        evt_d.rpt = 1'b1;
        rpt_cnt_d = RptReload;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RptW'(1);
      end
    end
  end

  always_ff @(posedge inClk) begin
    if (!n_reset) begin
      sync1_q   <= RESET_LEVEL;
      sync2_q   <= RESET_LEVEL;
      db_q      <= RESET_LEVEL;
      stab_q    <= '0;
      rpt_cnt_q <= '0;
      evt_q     <= EvtNone;
    end else begin
      sync1_q   <= button_i;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      stab_q    <= stab_d;
      rpt_cnt_q <= rpt_cnt_d;
      evt_q     <= evt_d;
    end
  end

  assign db_o   = db_q;
  assign rise_o = evt_q.rise;
  assign fall_o = evt_q.fall;
  assign rpt_o  = evt_q.rpt;

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent switch debouncers sharing one prescaled tick; event_any flags any pulse.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned CHANNELS     = 8,
  parameter int unsigned PRESCALE     = 1024,
  parameter int unsigned STABLE_TICKS = 32,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100,
  parameter logic        RESET_LEVEL  = 1'b0
) (
  input logic             inClk,
  input logic             n_reset,
  debounce_bank_if.slave  bus
);

  localparam int unsigned PreW = cnt_width(PRESCALE);
  localparam logic [PreW-1:0] PreLast = PreW'(PRESCALE - 1);

  logic [PreW-1:0] presc_q, presc_d;
  logic            tick;

  logic [CHANNELS-1:0] db_vec;
  logic [CHANNELS-1:0] rise_vec;
  logic [CHANNELS-1:0] fall_vec;
  logic [CHANNELS-1:0] rpt_vec;

  // With PRESCALE of 1 the count is pinned at zero and tick stays high.
  assign tick = (presc_q == PreLast);

  always_comb begin
    presc_d = presc_q + PreW'(1);
    if (tick) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge inClk) begin
    if (!n_reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_chan #(
      .STABLE_TICKS (STABLE_TICKS),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE),
      .RESET_LEVEL  (RESET_LEVEL)
    ) u_chan (
      .inClk       (inClk),
      .n_reset     (n_reset),
      .tick_i      (tick),
      .button_i    (bus.button_in[i]),
      .repeat_en_i (bus.repeat_en[i]),
      .db_o        (db_vec[i]),
      .rise_o      (rise_vec[i]),
      .fall_o      (fall_vec[i]),
      .rpt_o       (rpt_vec[i])
    );
  end

  assign bus.db_out    = db_vec;
  assign bus.rise      = rise_vec;
  assign bus.fall      = fall_vec;
  assign bus.rpt       = rpt_vec;
  assign bus.event_any = |(rise_vec | fall_vec | rpt_vec);

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: two instances (PRESCALE 1 and 4) against a behavioural model.
module tb_debounce_bank;

  localparam int NCH = 8;
  localparam int ST  = 4;
  localparam int RD  = 3;
  localparam int RR  = 2;

  logic inClk = 1'b0;
  logic n_reset = 1'b0;
  logic [NCH-1:0] btn = '0;
  logic [NCH-1:0] ren = '0;

  always #5 inClk = ~inClk;

  debounce_bank_if #(.CHANNELS(NCH)) bus_a ();
  debounce_bank_if #(.CHANNELS(NCH)) bus_b ();

  assign bus_a.button_in = btn;
  assign bus_a.repeat_en = ren;
  assign bus_b.button_in = btn;
  assign bus_b.repeat_en = ren;

  debounce_bank #(
    .CHANNELS(NCH), .PRESCALE(1), .STABLE_TICKS(ST), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
    .RESET_LEVEL(1'b0)
  ) dut_a (
    .inClk   (inClk),
    .n_reset (n_reset),
    .bus     (bus_a)
  );

  debounce_bank #(
    .CHANNELS(NCH), .PRESCALE(4), .STABLE_TICKS(ST), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
    .RESET_LEVEL(1'b0)
  ) dut_b (
    .inClk   (inClk),
    .n_reset (n_reset),
    .bus     (bus_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: index 0 is dut_a, 1 is dut_b.
  int       m_presc[2];
  bit [7:0] m_s1[2], m_s2[2], m_db[2], m_rise[2], m_fall[2], m_rpt[2];
  int       m_run[2][NCH];   // consecutive ticks with synchronised input != output
  int       m_held[2][NCH];  // ticks held with repeat enabled

  logic [7:0] obs_db[2], obs_rise[2], obs_fall[2], obs_rpt[2];
  logic       obs_ev[2];

  function automatic int pre_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic bit rpt_due(input int held);
    if (held == RD) return 1'b1;
    if (held > RD && ((held - RD) % RR) == 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_edge();
    bit tick;
    for (int k = 0; k < 2; k++) begin
      if (!n_reset) begin
        m_presc[k] = 0;
        m_s1[k] = '0; m_s2[k] = '0; m_db[k] = '0;
        m_rise[k] = '0; m_fall[k] = '0; m_rpt[k] = '0;
        for (int i = 0; i < NCH; i++) begin
          m_run[k][i] = 0;
          m_held[k][i] = 0;
        end
      end else begin
        tick = (m_presc[k] == pre_of(k) - 1);
        m_presc[k] = tick ? 0 : m_presc[k] + 1;
        for (int i = 0; i < NCH; i++) begin
          m_rpt[k][i] = 1'b0;
          if (!m_db[k][i] || !ren[i]) begin
            m_held[k][i] = 0;
          end else if (tick) begin
            m_held[k][i] = m_held[k][i] + 1;
            m_rpt[k][i] = rpt_due(m_held[k][i]);
          end
          m_rise[k][i] = 1'b0;
          m_fall[k][i] = 1'b0;
          if (m_s2[k][i] == m_db[k][i]) begin
            m_run[k][i] = 0;
          end else if (tick) begin
            m_run[k][i] = m_run[k][i] + 1;
            if (m_run[k][i] == ST) begin
              m_db[k][i] = m_s2[k][i];
              m_run[k][i] = 0;
              m_rise[k][i] = m_s2[k][i];
              m_fall[k][i] = ~m_s2[k][i];
            end
          end
          m_s2[k][i] = m_s1[k][i];
          m_s1[k][i] = btn[i];
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic step();
    string nm;
    @(posedge inClk);
    #1;
    cyc++;
    model_edge();
    obs_db[0] = bus_a.db_out; obs_rise[0] = bus_a.rise; obs_fall[0] = bus_a.fall;
    obs_rpt[0] = bus_a.rpt; obs_ev[0] = bus_a.event_any;
    obs_db[1] = bus_b.db_out; obs_rise[1] = bus_b.rise; obs_fall[1] = bus_b.fall;
    obs_rpt[1] = bus_b.rpt; obs_ev[1] = bus_b.event_any;
    for (int k = 0; k < 2; k++) begin
      nm = $sformatf("dut%0d cyc%0d", k, cyc);
      check({nm, " db_out"}, obs_db[k], m_db[k]);
      check({nm, " rise"}, obs_rise[k], m_rise[k]);
      check({nm, " fall"}, obs_fall[k], m_fall[k]);
      check({nm, " rpt"}, obs_rpt[k], m_rpt[k]);
      check({nm, " event_any"}, {7'b0, obs_ev[k]},
            {7'b0, |(m_rise[k] | m_fall[k] | m_rpt[k])});
    end
  endtask

  // Edges until every bit of mask shows rise on instance k; -1 if the budget runs out.
  task automatic wait_rise(input int k, input logic [7:0] mask, output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (lat < 0 && (obs_rise[k] & mask) == mask) lat = n;
      if (lat >= 0) n = 41;
    end
  endtask

  task automatic settle(input int n);
    for (int j = 0; j < n; j++) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int cnt;
    int first;

    // Reset state
    n_reset = 1'b0;
    settle(3);
    check("reset db_out", obs_db[0], 8'h00);
    n_reset = 1'b1;
    settle(2);

    // Clean press on channel 0, channel 1 untouched
    btn = 8'h01;
    wait_rise(0, 8'h01, lat);
    check_int("clean press latency", lat, 6, 6);
    check("clean press channel 1 untouched", obs_db[0], 8'h01);
    settle(20);
    btn = 8'h00;
    settle(25);

    // Bounce: toggle every 3 cycles for 30 cycles, then hold high
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (c % 3 == 0) btn[0] = ~btn[0];
      step();
      if (obs_db[0][0] !== 1'b0) cnt++;
    end
    check_int("bounce db_out changes", cnt, 0, 0);
    btn[0] = 1'b1;
    wait_rise(0, 8'h01, lat);
    check_int("bounce final latency", lat, 6, 6);
    settle(20);
    btn = 8'h00;
    settle(25);

    // Prescaled latency across all four tick phases
    for (int ph = 0; ph < 4; ph++) begin
      n_reset = 1'b0;
      step();
      n_reset = 1'b1;
      settle(ph);
      btn = 8'h01;
      wait_rise(1, 8'h01, lat);
      check_int($sformatf("prescale latency phase %0d", ph), lat, 15, 18);
      btn = 8'h00;
      settle(25);
    end

    // Auto-repeat on channel 0
    ren = 8'h01;
    btn = 8'h01;
    wait_rise(0, 8'h01, lat);
    cnt = 0;
    first = -1;
    for (int n = 1; n <= 7; n++) begin
      step();
      if (obs_rpt[0][0]) begin
        cnt++;
        if (first < 0) first = n;
      end
    end
    check_int("repeat pulses in 7 cycles", cnt, 3, 3);
    check_int("first repeat offset", first, 3, 3);
    btn = 8'h00;
    settle(25);
    ren = 8'h00;

    // Reset with the stability counter at 3 of 4
    btn = 8'h01;
    settle(5);
    n_reset = 1'b0;
    step();
    check("reset mid-count db_out", obs_db[0], 8'h00);
    check("reset mid-count rise", obs_rise[0], 8'h00);
    n_reset = 1'b1;
    wait_rise(0, 8'h01, lat);
    check_int("post-reset latency", lat, 6, 6);
    btn = 8'h00;
    settle(25);

    // All channels at once
    btn = 8'hFF;
    wait_rise(0, 8'hFF, lat);
    check_int("simultaneous latency", lat, 6, 6);
    check("simultaneous rise", obs_rise[0], 8'hFF);
    check("simultaneous event_any", {7'b0, obs_ev[0]}, 8'h01);
    step();
    check("event_any one cycle", {7'b0, obs_ev[0]}, 8'h00);
    btn = 8'h00;
    settle(25);

    // Random traffic including repeat-enable drops and occasional resets
    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(0, 19) == 0) begin
        n_reset = 1'b0;
        step();
        n_reset = 1'b1;
      end
      if ($urandom_range(0, 1) == 0) btn = 8'($urandom);
      else btn[$urandom_range(0, NCH - 1)] ^= 1'b1;
      if ($urandom_range(0, 3) == 0) ren = 8'($urandom);
      settle(int'($urandom_range(1, 24)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Multi-channel, parametrised switch debouncer for the Atari 5200 controller and console-key inputs. It replaces the single-channel DeBounce with one block that:
- debounces CHANNELS asynchronous inputs against a shared prescaled tick;
- emits a clean level plus one-cycle press and release pulses per channel;
- optionally generates key-repeat pulses for held keys.

It sits between the board input pins and the POKEY keyboard/trigger logic.

## Interface
Parameters:
- CHANNELS, 8, number of independent inputs.
- PRESCALE, 1024, inClk cycles per debounce tick (≥1).
- STABLE_TICKS, 32, consecutive ticks an input must differ from db_out before db_out changes (≥2).
- REPEAT_DELAY, 500, ticks of continuous high db_out before the first repeat pulse (≥1).
- REPEAT_RATE, 100, ticks between subsequent repeat pulses (≥1).
- RESET_LEVEL, 1'b0, value loaded into synchronisers and db_out at reset.

Ports:
- inClk, input, 1, system clock.
- n_reset, input, 1, reset, synchronous, active-low.
- button_in, input, CHANNELS, raw asynchronous inputs, active-high = pressed.
- repeat_en, input, CHANNELS, per-channel auto-repeat enable.
- db_out, output, CHANNELS, debounced level.
- rise, output, CHANNELS, one-cycle pulse when db_out goes 0→1.
- fall, output, CHANNELS, one-cycle pulse when db_out goes 1→0.
- rpt, output, CHANNELS, one-cycle auto-repeat pulse.
- event_any, output, 1, combinational OR of all rise, fall and rpt bits.

## Operation
Reset (n_reset low at a rising edge):
- sync1, sync2 and db_out are set to all RESET_LEVEL.
- Prescaler, stability counters and repeat counters are cleared.
- rise, fall and rpt are set to 0.

Prescaler:
- Counts 0..PRESCALE-1 and wraps.
- tick is high in the cycle the count equals PRESCALE-1.
- With PRESCALE=1, tick is constantly high.

Per channel, every cycle:
- Two-flop synchroniser: sync1 <= button_in[i], sync2 <= sync1. This path is not gated by tick.
- Stability counter (width clog2(STABLE_TICKS)):
  - sync2 == db_out: counter cleared every cycle, regardless of tick. Any glitch restarts the count.
  - sync2 != db_out and tick: if counter == STABLE_TICKS-1, then db_out <= sync2, counter <= 0, and rise or fall pulses high for exactly this cycle. Otherwise counter increments.
- Repeat counter:
  - Cleared whenever db_out is 0, repeat_en[i] is 0, or a rise occurs.
  - While db_out is 1 and repeat_en[i] is 1, it increments on tick.
  - rpt pulses when the count reaches REPEAT_DELAY. The counter then reloads to REPEAT_DELAY-REPEAT_RATE, so the next pulse comes REPEAT_RATE ticks later.
  - This continues until release or until repeat_en drops.
- rise and rpt never assert in the same cycle (first rpt ≥1 tick after rise).
- Channels are fully independent; simultaneous events on several channels all report in the same cycle.

## Timing
- All outputs are registered except event_any.
- Latency with PRESCALE=1: the first edge sampling a new stable level is edge 1. db_out and the pulse update at edge STABLE_TICKS+2.
- Latency with PRESCALE>1: from sync2 change to db_out change is between (STABLE_TICKS-1)·PRESCALE+1 and STABLE_TICKS·PRESCALE cycles, plus 2 synchroniser cycles.
- Pulses are exactly one inClk cycle wide and are not stretched to tick length.
- Reset mid-count: all progress is discarded. If the input already differs from RESET_LEVEL, the full STABLE_TICKS must elapse again after reset. No rise or fall is produced by reset itself.
- repeat_en deasserted mid-hold: no further rpt. Re-asserting repeat_en restarts from REPEAT_DELAY.
- Counter widths must be sized for the parameter maxima and must not wrap.

## Structure
- Shared header/package debounce_pkg: clog2 function and counter-width constants derived from the parameters.
- Sub-module debounce_chan: synchroniser, stability counter, repeat counter and pulse generation for one channel. It is instantiated CHANNELS times via generate.
- The prescaler and event_any live in debounce_bank.

## Test plan
- Clean press, CHANNELS=2, PRESCALE=1, STABLE_TICKS=4: button_in[0] 0→1 held. db_out[0]=1 and rise[0]=1 for one cycle at edge 6. Channel 1 stays untouched.
- Bounce: toggle button_in[0] every 3 cycles for 30 cycles, then hold 1. There is no db_out change during bouncing, and a single rise occurs 6 edges after the final transition.
- Prescaled timing, PRESCALE=4, STABLE_TICKS=4: measured press latency lies within 15..18 cycles across all four tick phases.
- Repeat, REPEAT_DELAY=3, REPEAT_RATE=2, PRESCALE=1, repeat_en[0]=1: after rise, rpt pulses 3, 5, 7, … cycles later. Release gives fall and stops rpt.
- Reset mid-count: assert n_reset with the counter at 3 of 4. All outputs are 0 in the next cycle, and the held input needs another 6 edges after n_reset rises.
- Simultaneous: all 8 channels press at once. All eight rise bits assert in the same cycle, and event_any is high for that one cycle.
